// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory-port arbiter.
//   bus_state_e        : arbiter FSM states (IDLE, ACCESS, ACK)
//   FLAG_READ/WRITE    : memory r/w flag encodings
//   PORT_CPU/PORT_IO   : requester port indices
//   DEFAULT_ADDR_W/_W  : default bus widths
//   CNT_W              : wait counter width
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } bus_state_e;

    localparam logic FLAG_READ  = 1'b0;
    localparam logic FLAG_WRITE = 1'b1;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IO  = 1'b1;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 16;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational 2-way round-robin picker.
//   req[1:0]    in  : request vector, bit index = port id
//   prio        in  : favoured port when both request
//   grant_valid out : at least one request present
//   grant_id    out : index of the winning port
module bus_rr_picker
    import cpu_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant_valid,
    output logic       grant_id
);

    assign grant_valid = |req;
    // With a lone request req[1] alone decides the winner; on contention prio does.
    assign grant_id    = (&req) ? prio : req[PORT_IO];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the single memory port between the CPU
// core (port 0) and the I/O/DMA engine (port 1), followed by a
// fixed-latency access sequencer.
//   clk, reset (async, active-low)
//   cpu_req/we/addr/wdata in, cpu_rdata/ack out : CPU requester
//   io_req/we/addr/wdata in,  io_rdata/ack out  : I/O requester
//   base, data_out, flag, mem_en out, data_in in : memory side
//   busy out : FSM not in IDLE
//
// state  | meaning
// IDLE   | wait for a request, grant and latch operands
// ACCESS | mem_en high, wait counter running down to 0
// ACK    | one-cycle ack to the served port
module bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_ack,
    output logic [ADDR_W-1:0] base,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    output logic              flag,
    output logic              mem_en,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_ACK    = ACK;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]       state;
    logic             prio;
    logic             owner;
    logic [CNT_W-1:0] wait_cnt;
    logic             grant_valid;
    logic             grant_id;

    bus_rr_picker u_picker (
        .req         ({io_req, cpu_req}),
        .prio        (prio),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            prio      <= PORT_CPU;
            owner     <= PORT_CPU;
            wait_cnt  <= '0;
            base      <= '0;
            data_out  <= '0;
            flag      <= FLAG_READ;
            mem_en    <= 1'b0;
            cpu_rdata <= '0;
            io_rdata  <= '0;
            cpu_ack   <= 1'b0;
            io_ack    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            io_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant_id;
                        prio     <= ~grant_id;
                        base     <= (grant_id == PORT_IO) ? io_addr  : cpu_addr;
                        data_out <= (grant_id == PORT_IO) ? io_wdata : cpu_wdata;
                        flag     <= (grant_id == PORT_IO) ? io_we    : cpu_we;
                        wait_cnt <= CNT_LOAD;
                        mem_en   <= 1'b1;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        if (flag == FLAG_READ) begin
                            if (owner == PORT_IO) io_rdata  <= data_in;
                            else                  cpu_rdata <= data_in;
                        end
                        // ack is raised on entry so it is high for the whole ACK cycle
                        if (owner == PORT_IO) io_ack  <= 1'b1;
                        else                  cpu_ack <= 1'b1;
                        mem_en <= 1'b0;
                        state  <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic [15:0] cpu_rdata, io_rdata;
    logic        cpu_ack, io_ack;
    logic [15:0] base, data_out, din;
    logic        flag, mem_en, busy;

    logic        w1_req;
    logic [15:0] w1_addr, w1_din;
    logic [15:0] w1_cpu_rdata, w1_io_rdata, w1_base, w1_data_out;
    logic        w1_cpu_ack, w1_io_ack, w1_flag, w1_mem_en, w1_busy;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .base(base), .data_out(data_out), .data_in(din), .flag(flag),
        .mem_en(mem_en), .busy(busy)
    );

    bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(w1_req), .cpu_we(1'b0), .cpu_addr(w1_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(w1_cpu_rdata), .cpu_ack(w1_cpu_ack),
        .io_req(1'b0), .io_we(1'b0), .io_addr(16'h0000), .io_wdata(16'h0000),
        .io_rdata(w1_io_rdata), .io_ack(w1_io_ack),
        .base(w1_base), .data_out(w1_data_out), .data_in(w1_din), .flag(w1_flag),
        .mem_en(w1_mem_en), .busy(w1_busy)
    );

    typedef struct {
        bit          port;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] last_rd [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every ack pops one expectation.
    always @(negedge clk) begin
        if (cpu_ack || io_ack) begin
            exp_t e;
            check("ack_exclusive", 32'(cpu_ack & io_ack), 0);
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, io_ack, cpu_ack}, 0);
            end else begin
                e = sb.pop_front();
                check("ack_port", 32'(io_ack), 32'(e.port));
                check("ack_rdata", e.port ? io_rdata : cpu_rdata, e.rdata);
            end
        end
    end

    task automatic push_exp(input bit port, input bit we, input logic [15:0] dval);
        exp_t e;
        e.port = port;
        if (!we) last_rd[port] = dval;
        e.rdata = last_rd[port];
        sb.push_back(e);
    endtask

    task automatic do_access(input bit port, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] dval,
                             input bit chg_addr);
        int lat = 0;
        int men = 0;
        bit got = 0;
        @(posedge clk); #1;
        din = dval;
        if (port) begin
            io_we = we; io_addr = addr; io_wdata = wdata; io_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        push_exp(port, we, dval);
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (mem_en) begin
                men++;
                check("base", base, addr);
                check("flag", 32'(flag), 32'(we));
                if (we) check("data_out", data_out, wdata);
                if (chg_addr && men == 1) cpu_addr = addr + 16'd1;
            end
            if (port ? io_ack : cpu_ack) begin
                got = 1;
                if (port) io_req = 1'b0; else cpu_req = 1'b0;
            end
        end
        check("ack_seen", 32'(got), 1);
        check("req_to_ack_latency", lat, 3);
        check("mem_en_cycles", men, 2);
        @(posedge clk); #1;
        check("ack_single_pulse", 32'(port ? io_ack : cpu_ack), 0);
        if (chg_addr) check("base_hold_after_access", base, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int nack, idle, last_ack_cyc, lat, men;
        bit got;
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        io_req = 0; io_we = 0; io_addr = 0; io_wdata = 0;
        din = 0; w1_req = 0; w1_addr = 0; w1_din = 0;
        last_rd[0] = 0; last_rd[1] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_base", base, 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_acks", {30'd0, io_ack, cpu_ack}, 0);
        check("rst_rdata", {cpu_rdata, io_rdata}, 0);
        reset = 1'b1;

        // CPU read alone, then IO write alone
        do_access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        do_access(1'b1, 1'b1, 16'h8000, 16'h1234, 16'hDEAD, 1'b0);
        check("io_rdata_after_write", io_rdata, 0);

        // Operand change during ACCESS
        do_access(1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0A0A, 1'b1);

        // Simultaneous requests from reset, both held
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd[0] = 0; last_rd[1] = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        din = 16'h5A5A;
        cpu_we = 0; cpu_addr = 16'h0100;
        io_we = 1; io_addr = 16'h0200; io_wdata = 16'h7777;
        push_exp(1'b0, 1'b0, 16'h5A5A);
        push_exp(1'b1, 1'b1, 16'h0000);
        push_exp(1'b0, 1'b0, 16'h5A5A);
        push_exp(1'b1, 1'b1, 16'h0000);
        cpu_req = 1; io_req = 1;
        nack = 0; idle = 0; last_ack_cyc = 0;
        for (int i = 0; i < 60 && nack < 4; i++) begin
            @(posedge clk); #1;
            if (!busy) idle++;
            if (cpu_ack || io_ack) begin
                nack++;
                if (nack > 1) begin
                    check("ack_spacing", cyc - last_ack_cyc, 4);
                    check("busy_low_gap", idle, 1);
                end
                last_ack_cyc = cyc;
                idle = 0;
                if (nack == 4) begin
                    cpu_req = 0; io_req = 0;
                end
            end
        end
        check("rr_ack_count", nack, 4);
        @(posedge clk); #1;

        // Reset mid-access: CPU access first so prio points at IO
        do_access(1'b0, 1'b0, 16'h0300, 16'h0000, 16'h1111, 1'b0);
        @(posedge clk); #1;
        io_we = 0; io_addr = 16'h0400; io_req = 1;
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("midrst_mem_en", 32'(mem_en), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_base", base, 0);
        check("midrst_flag_dout", {15'd0, flag, data_out}, 0);
        check("midrst_rdata", {cpu_rdata, io_rdata}, 0);
        last_rd[0] = 0; last_rd[1] = 0;
        din = 16'h2222;
        cpu_we = 0; cpu_addr = 16'h0500; cpu_req = 1;
        push_exp(1'b0, 1'b0, 16'h2222);
        push_exp(1'b1, 1'b0, 16'h2222);
        @(posedge clk); #1;
        check("midrst_no_ack", {30'd0, io_ack, cpu_ack}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        nack = 0;
        for (int i = 0; i < 30 && nack < 2; i++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin cpu_req = 0; nack++; end
            if (io_ack)  begin io_req = 0;  nack++; end
        end
        check("post_reset_ack_count", nack, 2);
        @(posedge clk); #1;

        // WAIT_CYCLES = 1 instance
        w1_addr = 16'h0042; w1_din = 16'hC0DE; w1_req = 1;
        lat = 0; men = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (w1_mem_en) begin
                men++;
                check("w1_base", w1_base, 16'h0042);
            end
            if (w1_cpu_ack) begin
                got = 1;
                w1_req = 0;
                check("w1_rdata", w1_cpu_rdata, 16'hC0DE);
            end
        end
        check("w1_ack_seen", 32'(got), 1);
        check("w1_latency", lat, 2);
        check("w1_mem_en_cycles", men, 1);
        @(posedge clk); #1;
        check("w1_ack_single_pulse", 32'(w1_cpu_ack), 0);
        check("w1_io_ack_quiet", 32'(w1_io_ack), 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
